// File: rtl/aes_ct_byte_packer.sv
// Byte-serial to 128-bit ciphertext block packer: an assembly register fills MSB-first,
// then hands a complete block to a one-entry output register feeding the decrypt core.
module aes_ct_byte_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_vld,
    output logic             byte_rdy,
    output logic [127:0]     ct,
    output logic             ct_vld,
    input  logic             ct_rdy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic [4:0]       fill
);

    logic [127:0]     r_asm;
    logic [4:0]       r_fill;
    logic [127:0]     r_out;
    logic             r_ct_vld;
    logic [CNT_W-1:0] r_blk_cnt;

    logic w_full;
    logic w_byte_xfer;
    logic w_blk_xfer;
    logic w_move;

    // Readiness depends only on fill state, never on byte_vld or ct_rdy.
    assign w_full      = r_fill[4];
    assign w_byte_xfer = byte_vld && !w_full;
    assign w_blk_xfer  = r_ct_vld && ct_rdy;
    assign w_move      = w_full && (!r_ct_vld || w_blk_xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm     <= '0;
            r_fill    <= '0;
            r_out     <= '0;
            r_ct_vld  <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            if (w_move) begin
                r_out    <= r_asm;
                r_ct_vld <= 1'b1;
                r_fill   <= '0;
            end else if (w_blk_xfer) begin
                r_ct_vld <= 1'b0;
            end
            // Shifting in at the bottom leaves the first byte of the block at [127:120]
            // once sixteen bytes have arrived; w_move and w_byte_xfer never coincide.
            if (w_byte_xfer) begin
                r_asm  <= {r_asm[119:0], byte_in};
                r_fill <= r_fill + 5'd1;
            end
            if (w_blk_xfer)
                r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign byte_rdy = !w_full;
    assign ct       = r_out;
    assign ct_vld   = r_ct_vld;
    assign blk_cnt  = r_blk_cnt;
    assign fill     = r_fill;

endmodule

// File: tb/tb_aes_ct_byte_packer.sv
// Randomized and directed bench for aes_ct_byte_packer against a byte-queue reference model.
module tb_aes_ct_byte_packer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       byte_in = '0;
    logic             byte_vld = 1'b0;
    logic             byte_rdy;
    logic [127:0]     ct;
    logic             ct_vld;
    logic             ct_rdy = 1'b0;
    logic [CNT_W-1:0] blk_cnt;
    logic [4:0]       fill;

    aes_ct_byte_packer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
        .ct(ct), .ct_vld(ct_vld), .ct_rdy(ct_rdy), .blk_cnt(blk_cnt), .fill(fill)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes waiting in assembly, one output slot, delivered-block count.
    logic [7:0]       m_q[$];
    logic [127:0]     m_out = '0;
    logic             m_vld = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               started = 1'b0;

    always @(posedge clk) begin
        bit bx, bk, mv;
        started = 1'b1;
        if (rst) begin
            m_q.delete();
            m_out = '0;
            m_vld = 1'b0;
            m_cnt = '0;
        end else begin
            bx = byte_vld && (m_q.size() < 16);
            bk = m_vld && ct_rdy;
            mv = (m_q.size() == 16) && (!m_vld || bk);
            if (bk) m_cnt = m_cnt + 1'b1;
            if (mv) begin
                for (int k = 0; k < 16; k++) m_out[127-8*k -: 8] = m_q[k];
                m_q.delete();
                m_vld = 1'b1;
            end else if (bk) begin
                m_vld = 1'b0;
            end
            if (bx) m_q.push_back(byte_in);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("fill",     128'(fill),     128'(m_q.size()));
            chk("byte_rdy", 128'(byte_rdy), 128'(m_q.size() < 16));
            chk("ct_vld",   128'(ct_vld),   128'(m_vld));
            chk("ct",       ct,             m_out);
            chk("blk_cnt",  128'(blk_cnt),  128'(m_cnt));
        end
    end

    // Delivered-block monitor for the directed scenarios.
    logic [127:0]     dlv[$];
    logic [CNT_W-1:0] cnts[$];
    bit               dlv_flag = 1'b0;
    int               vld_cycles = 0;

    always @(posedge clk) begin
        if (!rst && ct_vld && ct_rdy) begin
            dlv.push_back(ct);
            dlv_flag = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (ct_vld) vld_cycles++;
        if (dlv_flag) begin
            cnts.push_back(blk_cnt);
            dlv_flag = 1'b0;
        end
    end

    function automatic logic [127:0] pack(input logic [7:0] base);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = base + 8'(k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        byte_vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_vld = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Offer one byte until accepted; duty<100 randomizes byte_vld and ct_rdy per cycle.
    task automatic put_byte(input logic [7:0] b, input int duty);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            byte_in = b;
            if (duty >= 100) byte_vld = 1'b1;
            else begin
                byte_vld = ($urandom_range(0, 99) < duty);
                ct_rdy   = ($urandom_range(0, 99) < 70);
            end
            acc = byte_vld && byte_rdy;
            step();
        end
        if (!acc) chk("put_timeout", 128'd0, 128'd1);
    endtask

    task automatic put_block(input logic [7:0] base);
        for (int k = 0; k < 16; k++) put_byte(base + 8'(k), 100);
    endtask

    logic [7:0] sent[$];

    initial begin
        // Reset state
        do_reset();
        chk("rst_fill",    128'(fill),     128'd0);
        chk("rst_ct_vld",  128'(ct_vld),   128'd0);
        chk("rst_byte_rdy",128'(byte_rdy), 128'd1);
        chk("rst_blk_cnt", 128'(blk_cnt),  128'd0);
        chk("rst_ct",      ct,             128'd0);

        // Single block at full rate
        ct_rdy = 1'b1;
        dlv.delete();
        vld_cycles = 0;
        put_block(8'h00);
        idle(4);
        chk("single_n",    128'(dlv.size()), 128'd1);
        if (dlv.size() >= 1) chk("single_ct", dlv[0], 128'h000102030405060708090A0B0C0D0E0F);
        chk("single_vld_cycles", 128'(vld_cycles), 128'd1);
        chk("single_blk_cnt",    128'(blk_cnt),    128'd1);

        // Backpressure with two blocks streamed
        ct_rdy = 1'b0;
        dlv.delete();
        put_block(8'h10);
        put_block(8'h20);
        idle(3);
        chk("bp_fill",     128'(fill),     128'd16);
        chk("bp_byte_rdy", 128'(byte_rdy), 128'd0);
        chk("bp_ct_hold",  ct,             pack(8'h10));
        ct_rdy = 1'b1;
        step();
        chk("bp_ct2",      ct,             pack(8'h20));
        chk("bp_vld2",     128'(ct_vld),   128'd1);
        step();
        idle(2);
        chk("bp_n", 128'(dlv.size()), 128'd2);
        if (dlv.size() >= 2) begin
            chk("bp_blk1", dlv[0], pack(8'h10));
            chk("bp_blk2", dlv[1], pack(8'h20));
        end

        // Gapped random input, random core readiness
        dlv.delete();
        sent.delete();
        for (int i = 0; i < 48; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sent.push_back(b);
            put_byte(b, 30);
        end
        byte_vld = 1'b0;
        ct_rdy = 1'b1;
        idle(40);
        chk("gap_n", 128'(dlv.size()), 128'd3);
        for (int j = 0; j < 3 && j < dlv.size(); j++) begin
            logic [127:0] e;
            for (int k = 0; k < 16; k++) e[127-8*k -: 8] = sent[16*j+k];
            chk("gap_blk", dlv[j], e);
        end

        // Reset mid-block, with a byte offered on the reset edge
        dlv.delete();
        for (int k = 0; k < 7; k++) put_byte(8'hA0 + 8'(k), 100);
        rst = 1'b1;
        byte_vld = 1'b1;
        step();
        rst = 1'b0;
        byte_vld = 1'b0;
        chk("mid_rst_fill",   128'(fill),   128'd0);
        chk("mid_rst_ct_vld", 128'(ct_vld), 128'd0);
        put_block(8'h60);
        idle(3);
        chk("mid_rst_n", 128'(dlv.size()), 128'd1);
        if (dlv.size() >= 1) chk("mid_rst_blk", dlv[0], pack(8'h60));

        // Counter wrap with CNT_W=2
        do_reset();
        cnts.delete();
        ct_rdy = 1'b1;
        for (int b = 0; b < 5; b++) put_block(8'(16*b));
        idle(3);
        chk("wrap_n", 128'(cnts.size()), 128'd5);
        if (cnts.size() >= 5) begin
            chk("wrap0", 128'(cnts[0]), 128'd1);
            chk("wrap1", 128'(cnts[1]), 128'd2);
            chk("wrap2", 128'(cnts[2]), 128'd3);
            chk("wrap3", 128'(cnts[3]), 128'd0);
            chk("wrap4", 128'(cnts[4]), 128'd1);
        end

        // First byte of block N+1 accepted on the edge that delivers block N
        do_reset();
        dlv.delete();
        ct_rdy = 1'b0;
        put_block(8'h40);
        byte_vld = 1'b0;
        for (int t = 0; t < 10 && !ct_vld; t++) step();
        chk("sim_vld_ready", 128'(ct_vld), 128'd1);
        byte_in  = 8'h50;
        byte_vld = 1'b1;
        ct_rdy   = 1'b1;
        step();
        chk("sim_fill",   128'(fill),   128'd1);
        chk("sim_ct_vld", 128'(ct_vld), 128'd0);
        for (int k = 1; k < 16; k++) put_byte(8'h50 + 8'(k), 100);
        idle(4);
        chk("sim_n", 128'(dlv.size()), 128'd2);
        if (dlv.size() >= 2) begin
            chk("sim_blkN",  dlv[0], pack(8'h40));
            chk("sim_blkN1", dlv[1], pack(8'h50));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
